// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle: req/ack handshake plus rvalid/rdata return.
// Fetch side drives the request as master; memory is the slave.
interface if_fetch_unit_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic              imem_rvalid;
   logic [INST_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: one outstanding imem access, one-entry instruction buffer toward IF/ID; optional IF_FETCH_PERF_EN counters.
// Latency: inst valid the cycle after imem_rvalid; stalls PC while an access is outstanding or buffer is blocked.
// Backpressure: id_ready low with a full buffer suppresses new requests; flush kills buffer and in-flight data.
module if_fetch_unit #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] pc,
   input  logic              if_request,
   input  logic              flush,
   input  logic              id_ready,
   if_fetch_unit_if.master   imem,
   output logic [INST_W-1:0] inst_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              valid_out,
   output logic              stall_if
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic              valid_q, valid_d;
   logic              req;
   logic              accept;
   logic              deliver;

   assign req     = (state_q == S_IDLE) & if_request & ~flush & (~valid_q | id_ready);
   assign accept  = req & imem.imem_ack;
   assign deliver = (state_q == S_WAIT) & imem.imem_rvalid & ~flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A flush in WAIT without data leaves the response still owed; DROP swallows it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_WAIT;
         S_WAIT: begin
            if (imem.imem_rvalid) state_d = S_IDLE;
            else if (flush)       state_d = S_DROP;
         end
         S_DROP: if (imem.imem_rvalid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem.imem_req  = req;
      imem.imem_addr = pc;
      stall_if = ~flush & ( (req & ~imem.imem_ack)
                          | (state_q == S_WAIT)
                          | (state_q == S_DROP)
                          | ((state_q == S_IDLE) & if_request & valid_q & ~id_ready) );
   end

   always_comb begin
      pc_d     = accept ? pc : pc_q;
      inst_d   = inst_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      // Loading a new instruction takes priority over the consume-clear.
      if (deliver) begin
         inst_d   = imem.imem_rdata;
         pc_out_d = pc_q;
         valid_d  = 1'b1;
      end else if (flush || (valid_q && id_ready)) begin
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q     <= '0;
         inst_q   <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
      end
   end

   assign inst_out  = inst_q;
   assign pc_out    = pc_out_q;
   assign valid_out = valid_q;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'd0, (valid_q & id_ready)};
      stall_cnt_d = stall_cnt_q + {31'd0, stall_if};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_if_fetch_unit;
   localparam int ADDR_W = 64;
   localparam int INST_W = 32;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [ADDR_W-1:0] pc = '0;
   logic              if_request = 1'b0;
   logic              flush = 1'b0;
   logic              id_ready = 1'b0;
   logic [INST_W-1:0] inst_out;
   logic [ADDR_W-1:0] pc_out;
   logic              valid_out;
   logic              stall_if;
`ifdef IF_FETCH_PERF_EN
   logic [31:0]       perf_fetch_cnt;
   logic [31:0]       perf_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   if_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) imem_bus ();

   if_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .pc         (pc),
      .if_request (if_request),
      .flush      (flush),
      .id_ready   (id_ready),
      .imem       (imem_bus),
      .inst_out   (inst_out),
      .pc_out     (pc_out),
      .valid_out  (valid_out),
      .stall_if   (stall_if)
`ifdef IF_FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      if_request = 1'b0;
      flush      = 1'b0;
      id_ready   = 1'b0;
      imem_bus.imem_ack    = 1'b0;
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = '0;
   endtask

   task automatic test_reset();
      quiet_inputs();
      rstn = 1'b0;
      #12;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
      checks++; if (inst_out !== '0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst_out); end
      checks++; if (pc_out !== '0) begin errors++; $display("FAIL reset_pc_out got %h exp 0", pc_out); end
      checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_if); end
      checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_bus.imem_req); end
      @(negedge clk);
      rstn = 1'b1;
      // A stray response while idle after reset must be ignored.
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = 32'hBAD0BAD0;
      tick();
      imem_bus.imem_rvalid = 1'b0;
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_stray_rvalid got %b exp 0", valid_out); end
   endtask

   task automatic test_single_fetch();
      pc = 64'h1000; if_request = 1'b1; id_ready = 1'b1; imem_bus.imem_ack = 1'b1;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 64'h1000) begin
         errors++; $display("FAIL single_req got %b/%h exp 1/1000", imem_bus.imem_req, imem_bus.imem_addr); end
      checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL single_stall_accept got %b exp 0", stall_if); end
      tick();
      if_request = 1'b0; imem_bus.imem_ack = 1'b0;
      #1;
      checks++; if (stall_if !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL single_wait1 got stall %b req %b exp 1/0", stall_if, imem_bus.imem_req); end
      tick();
      imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h00500093;
      #1;
      checks++; if (stall_if !== 1'b1 || valid_out !== 1'b0) begin
         errors++; $display("FAIL single_wait2 got stall %b valid %b exp 1/0", stall_if, valid_out); end
      tick();
      imem_bus.imem_rvalid = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b1 || inst_out !== 32'h00500093 || pc_out !== 64'h1000) begin
         errors++; $display("FAIL single_deliver got %b %h %h exp 1 00500093 1000", valid_out, inst_out, pc_out); end
      checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL single_stall_done got %b exp 0", stall_if); end
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_consumed got %b exp 0", valid_out); end
   endtask

   // Ack delay, then back-pressure on the delivered instruction, then the next request.
   task automatic test_ack_delay_backpressure();
      pc = 64'h1000; if_request = 1'b1; id_ready = 1'b0; imem_bus.imem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 64'h1000 || stall_if !== 1'b1) begin
            errors++; $display("FAIL ack_delay_%0d got req %b addr %h stall %b exp 1 1000 1", i,
                               imem_bus.imem_req, imem_bus.imem_addr, stall_if); end
         tick();
      end
      imem_bus.imem_ack = 1'b1;
      tick();
      imem_bus.imem_ack = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h00A00113;
      tick();
      imem_bus.imem_rvalid = 1'b0; pc = 64'h1004;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (imem_bus.imem_req !== 1'b0 || stall_if !== 1'b1 || valid_out !== 1'b1 || inst_out !== 32'h00A00113) begin
            errors++; $display("FAIL backpressure_%0d got req %b stall %b valid %b inst %h exp 0 1 1 00a00113", i,
                               imem_bus.imem_req, stall_if, valid_out, inst_out); end
         tick();
      end
      id_ready = 1'b1; imem_bus.imem_ack = 1'b1;
      #1;
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 64'h1004) begin
         errors++; $display("FAIL bp_release got req %b addr %h exp 1 1004", imem_bus.imem_req, imem_bus.imem_addr); end
      tick();
      imem_bus.imem_ack = 1'b0;
   endtask

   // Entered with the fetch of 0x1004 outstanding.
   task automatic test_flush_wait();
      flush = 1'b1; pc = 64'h2000; if_request = 1'b1;
      #1;
      checks++; if (stall_if !== 1'b0 || imem_bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL flush_cycle got stall %b req %b exp 0 0", stall_if, imem_bus.imem_req); end
      tick();
      flush = 1'b0;
      #1;
      checks++; if (stall_if !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL flush_drop got stall %b req %b exp 1 0", stall_if, imem_bus.imem_req); end
      tick();
      imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hDEADBEEF;
      tick();
      imem_bus.imem_rvalid = 1'b0; imem_bus.imem_ack = 1'b1;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_stale got valid %b inst %h exp 0", valid_out, inst_out); end
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 64'h2000) begin
         errors++; $display("FAIL flush_redirect got req %b addr %h exp 1 2000", imem_bus.imem_req, imem_bus.imem_addr); end
      tick();
      imem_bus.imem_ack = 1'b0;
   endtask

   // Entered with the fetch of 0x2000 outstanding.
   task automatic test_flush_rvalid();
      flush = 1'b1; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h11111111;
      #1;
      checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL flush_rv_stall got %b exp 0", stall_if); end
      tick();
      flush = 1'b0; imem_bus.imem_rvalid = 1'b0; if_request = 1'b1; pc = 64'h3000;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_rv_drop got %b exp 0", valid_out); end
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 64'h3000) begin
         errors++; $display("FAIL flush_rv_idle got req %b addr %h exp 1 3000", imem_bus.imem_req, imem_bus.imem_addr); end
      if_request = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      pc = 64'h4000; if_request = 1'b1; imem_bus.imem_ack = 1'b1;
      tick();
      if_request = 1'b0; imem_bus.imem_ack = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0 || stall_if !== 1'b0) begin
         errors++; $display("FAIL reset_async got valid %b stall %b exp 0 0", valid_out, stall_if); end
      @(negedge clk);
      rstn = 1'b1;
      imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h77777777;
      tick();
      imem_bus.imem_rvalid = 1'b0;
      tick();
      checks++; if (valid_out !== 1'b0 || stall_if !== 1'b0) begin
         errors++; $display("FAIL reset_late_rvalid got valid %b stall %b exp 0 0", valid_out, stall_if); end
   endtask

   // Model: "busy" = an access is owed a response, "killed" = that response is unwanted.
   task automatic test_random();
      bit              m_busy = 0, m_killed = 0, m_valid = 0;
      logic [31:0]     m_inst = '0;
      logic [63:0]     m_pc = '0, req_pc = '0;
      bit              mem_pending = 0;
      int              mem_wait = 0;
      bit              exp_req, exp_stall, rv, ack, deliver;
      int unsigned     fetch_cnt = 0, stall_cnt = 0;
      int              deliveries = 0;
      quiet_inputs();
      rstn = 1'b0;
      #3;
      rstn = 1'b1;
      tick();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         checks++; if (valid_out !== m_valid) begin
            errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", cyc, valid_out, m_valid); end
         if (m_valid) begin
            checks++; if (inst_out !== m_inst || pc_out !== m_pc) begin
               errors++; $display("FAIL rand_data cyc %0d got %h/%h exp %h/%h", cyc, inst_out, pc_out, m_inst, m_pc); end
         end
         if_request = ($urandom_range(0, 9) < 8);
         flush      = ($urandom_range(0, 9) == 0);
         id_ready   = ($urandom_range(0, 9) < 7);
         ack        = ($urandom_range(0, 9) < 6);
         pc         = {$urandom, $urandom} & ~64'h3;
         rv = 1'b0;
         if (mem_pending) begin
            if (mem_wait == 0) begin rv = 1'b1; mem_pending = 0; end
            else mem_wait--;
         end else begin
            rv = ($urandom_range(0, 7) == 0);
         end
         imem_bus.imem_ack    = ack;
         imem_bus.imem_rvalid = rv;
         imem_bus.imem_rdata  = $urandom;
         #1;
         exp_req   = !m_busy && if_request && !flush && (!m_valid || id_ready);
         exp_stall = !flush && ((exp_req && !ack) || m_busy || (!m_busy && if_request && m_valid && !id_ready));
         checks++; if (imem_bus.imem_req !== exp_req) begin
            errors++; $display("FAIL rand_req cyc %0d got %b exp %b", cyc, imem_bus.imem_req, exp_req); end
         if (exp_req) begin
            checks++; if (imem_bus.imem_addr !== pc) begin
               errors++; $display("FAIL rand_addr cyc %0d got %h exp %h", cyc, imem_bus.imem_addr, pc); end
         end
         checks++; if (stall_if !== exp_stall) begin
            errors++; $display("FAIL rand_stall cyc %0d got %b exp %b", cyc, stall_if, exp_stall); end
         fetch_cnt += (m_valid && id_ready) ? 1 : 0;
         stall_cnt += exp_stall ? 1 : 0;
         deliver = m_busy && !m_killed && rv && !flush;
         if (deliver) begin
            m_valid = 1; m_inst = imem_bus.imem_rdata; m_pc = req_pc; deliveries++;
         end else if (flush || (m_valid && id_ready)) begin
            m_valid = 0;
         end
         if (m_busy && rv) begin m_busy = 0; m_killed = 0; end
         else if (m_busy && flush) m_killed = 1;
         if (exp_req && ack) begin
            m_busy = 1; m_killed = 0; req_pc = pc;
            mem_pending = 1; mem_wait = $urandom_range(0, 3);
         end
         tick();
      end
      checks++; if (deliveries < 50) begin errors++; $display("FAIL rand_activity got %0d deliveries exp >=50", deliveries); end
`ifdef IF_FETCH_PERF_EN
      checks++; if (perf_fetch_cnt !== fetch_cnt) begin
         errors++; $display("FAIL perf_fetch got %0d exp %0d", perf_fetch_cnt, fetch_cnt); end
      checks++; if (perf_stall_cnt !== stall_cnt) begin
         errors++; $display("FAIL perf_stall got %0d exp %0d", perf_stall_cnt, stall_cnt); end
`endif
      quiet_inputs();
   endtask

   initial begin
      quiet_inputs();
      test_reset();
      test_single_fetch();
      test_ack_delay_backpressure();
      test_flush_wait();
      test_flush_rvalid();
      test_reset_mid_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
